code_verifier: RTL and testbench

CODE_VERIFIER -- requirements
Module: code_verifier

---
 rtl/code_verifier.sv | 179 +++++++++++++++++
 tb/tb_code_verifier.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/code_verifier.sv
// ============================================================================
// code_verifier : digit-serial code comparator with failure lockout.
// Optional macro CODE_VERIFIER_EARLY_ABORT_EN ends a compare on first bad digit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module code_verifier #(
  parameter int DIGITS      = 6,
  parameter int DIGIT_W     = 4,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 1000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [DIGITS*DIGIT_W-1:0]         entered,
  input  logic [DIGITS*DIGIT_W-1:0]         stored,
  output logic                              busy,
  output logic                              done,
  output logic                              match,
  output logic                              locked,
  output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt
);

  localparam int CODE_W = DIGITS * DIGIT_W;
  localparam int FC_W   = $clog2(MAX_FAIL + 1);
  localparam int LC_W   = $clog2(LOCK_CYCLES + 1);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [FC_W-1:0]  C_MAX_FAIL    = FC_W'(MAX_FAIL);
  localparam logic [LC_W-1:0]  C_LOCK_CYCLES = LC_W'(LOCK_CYCLES);
  localparam logic [IDX_W-1:0] C_LAST_IDX    = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  state_t            state_q,    state_d;
  logic [CODE_W-1:0] ent_q,      ent_d;
  logic [CODE_W-1:0] sto_q,      sto_d;
  logic [IDX_W-1:0]  idx_q,      idx_d;
  logic              acc_q,      acc_d;
  logic [LC_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [FC_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic              match_q,    match_d;
  logic              locked_q,   locked_d;

  logic              w_digit_diff;
  logic              w_acc;
  logic              w_last;
  logic              w_abort;
  logic              w_finish;
  logic [FC_W-1:0]   w_fail_inc;

  // Captured codes shift down one digit per compare, so digit k sits at the LSBs
  // on the (k+1)th CMP edge.
  assign w_digit_diff = (ent_q[DIGIT_W-1:0] != sto_q[DIGIT_W-1:0]);
  assign w_acc        = acc_q | w_digit_diff;
  assign w_last       = (idx_q == C_LAST_IDX);
  assign w_fail_inc   = fail_cnt_q + FC_W'(1);

`ifdef CODE_VERIFIER_EARLY_ABORT_EN
  assign w_abort = w_digit_diff;
`else
  assign w_abort = 1'b0;
`endif

  assign w_finish = w_last | w_abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ent_q      <= '0;
      sto_q      <= '0;
      idx_q      <= '0;
      acc_q      <= 1'b0;
      lock_cnt_q <= '0;
      fail_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      match_q    <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ent_q      <= ent_d;
      sto_q      <= sto_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      lock_cnt_q <= lock_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      match_q    <= match_d;
      locked_q   <= locked_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ent_d      = ent_q;
    sto_d      = sto_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    lock_cnt_d = lock_cnt_q;
    fail_cnt_d = fail_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    match_d    = match_q;
    locked_d   = locked_q;

    case (state_q)
      S_IDLE: begin
        if (start && !locked_q) begin
          ent_d   = entered;
          sto_d   = stored;
          acc_d   = 1'b0;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_CMP;
        end
      end

      S_CMP: begin
        acc_d = w_acc;
        if (w_finish) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          match_d = ~w_acc;
          if (!w_acc) begin
            fail_cnt_d = '0;
            state_d    = S_IDLE;
          end else if (w_fail_inc == C_MAX_FAIL) begin
            fail_cnt_d = w_fail_inc;
            locked_d   = 1'b1;
            lock_cnt_d = C_LOCK_CYCLES;
            state_d    = S_LOCK;
          end else begin
            fail_cnt_d = w_fail_inc;
            state_d    = S_IDLE;
          end
        end else begin
          idx_d = idx_q + IDX_W'(1);
          ent_d = ent_q >> DIGIT_W;
          sto_d = sto_q >> DIGIT_W;
        end
      end

      S_LOCK: begin
        // Expiry edge returns to IDLE; a start on this same edge is not seen.
        if (lock_cnt_q <= LC_W'(1)) begin
          lock_cnt_d = '0;
          locked_d   = 1'b0;
          fail_cnt_d = '0;
          state_d    = S_IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q - LC_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign match    = match_q;
  assign locked   = locked_q;
  assign fail_cnt = fail_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_code_verifier.sv
// ============================================================================
// tb_code_verifier : randomized self-checking bench for code_verifier.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_code_verifier;

  localparam int DIGITS      = 6;
  localparam int DIGIT_W     = 4;
  localparam int MAX_FAIL    = 3;
  localparam int LOCK_CYCLES = 20;
  localparam int W           = DIGITS * DIGIT_W;
  localparam int FC_W        = $clog2(MAX_FAIL + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [W-1:0]    entered;
  logic [W-1:0]    stored;
  logic            busy;
  logic            done;
  logic            match;
  logic            locked;
  logic [FC_W-1:0] fail_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int m_fail = 0;
  bit m_locked = 1'b0;
  int lock_elapsed = 0;

  code_verifier #(
    .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .entered(entered), .stored(stored),
    .busy(busy), .done(done), .match(match), .locked(locked), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected number of edges from acceptance to the result.
  function automatic int exp_lat(input logic [W-1:0] e, input logic [W-1:0] s);
    int lat;
    lat = DIGITS;
`ifdef CODE_VERIFIER_EARLY_ABORT_EN
    for (int k = DIGITS - 1; k >= 0; k--)
      if (e[k*DIGIT_W +: DIGIT_W] != s[k*DIGIT_W +: DIGIT_W]) lat = k + 1;
`endif
    return lat;
  endfunction

  // One full transaction from IDLE; inputs are scrambled after acceptance.
  task automatic run_cmp(input logic [W-1:0] ent, input logic [W-1:0] sto, input string tag);
    int lat;
    int cyc;
    logic exp_m;
    lat   = exp_lat(ent, sto);
    exp_m = (ent == sto);
    entered = ent;
    stored  = sto;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    entered = W'($urandom);
    stored  = W'($urandom);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL %s accept: busy=%b want 1", tag, busy);
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    if (exp_m) m_fail = 0; else m_fail++;
    m_locked = (m_fail == MAX_FAIL);
    n_cmp++;
    if (cyc != lat) begin
      n_bad++; $display("FAIL %s latency: got %0d want %0d", tag, cyc, lat);
    end
    n_cmp++;
    if (match !== exp_m || busy !== 1'b0) begin
      n_bad++; $display("FAIL %s result: match=%b busy=%b want match=%b busy=0", tag, match, busy, exp_m);
    end
    n_cmp++;
    if (fail_cnt !== FC_W'(m_fail) || locked !== m_locked) begin
      n_bad++; $display("FAIL %s fail/lock: fail_cnt=%0d locked=%b want %0d %b",
                        tag, fail_cnt, locked, m_fail, m_locked);
    end
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL %s done_pulse: done=%b want 0", tag, done);
    end
    if (m_locked) lock_elapsed = 1;
  endtask

  task automatic wait_lockout(input string tag);
    while (locked === 1'b1 && lock_elapsed < 40) begin
      tick();
      lock_elapsed++;
    end
    n_cmp++;
    if (lock_elapsed != LOCK_CYCLES || fail_cnt !== '0) begin
      n_bad++; $display("FAIL %s lock_len: cycles=%0d fail_cnt=%0d want %0d 0",
                        tag, lock_elapsed, fail_cnt, LOCK_CYCLES);
    end
    m_fail   = 0;
    m_locked = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; entered = '0; stored = '0;
    repeat (2) tick();
    n_cmp++;
    if ({busy, done, match, locked, fail_cnt} !== '0) begin
      n_bad++; $display("FAIL reset_state: busy=%b done=%b match=%b locked=%b fail_cnt=%0d want all 0",
                        busy, done, match, locked, fail_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_match();
    run_cmp(24'h123456, 24'h123456, "match");
  endtask

  task automatic test_mismatch_digit0();
    run_cmp(24'h123457, 24'h123456, "mismatch_d0");
  endtask

  task automatic test_fail_sequence();
    bit saw_lock;
    run_cmp(24'hABCDEF, 24'hABCDEF, "seq_clear");
    run_cmp(24'h000001, 24'h100000, "seq_f1");
    saw_lock = locked;
    run_cmp(24'h999999, 24'h999998, "seq_f2");
    saw_lock |= locked;
    run_cmp(24'h424242, 24'h424242, "seq_ok");
    saw_lock |= locked;
    n_cmp++;
    if (saw_lock) begin
      n_bad++; $display("FAIL seq_no_lock: locked seen=1 want 0");
    end
  endtask

  task automatic test_lockout();
    bit bad_hold;
    int cyc;
    logic [W-1:0] code;
    run_cmp(24'h111111, 24'h211111, "lock_f1");
    run_cmp(24'h111111, 24'h121111, "lock_f2");
    run_cmp(24'h111111, 24'h111112, "lock_f3");
    start = 1'b1;
    tick();
    start = 1'b0;
    lock_elapsed++;
    n_cmp++;
    if (busy !== 1'b0 || locked !== 1'b1) begin
      n_bad++; $display("FAIL lock_ignore_start: busy=%b locked=%b want 0 1", busy, locked);
    end
    bad_hold = 1'b0;
    while (lock_elapsed < LOCK_CYCLES - 1) begin
      tick();
      lock_elapsed++;
      if (locked !== 1'b1) bad_hold = 1'b1;
    end
    n_cmp++;
    if (bad_hold) begin
      n_bad++; $display("FAIL lock_hold: locked dropped early, got 0 want 1");
    end
    code = W'($urandom);
    entered = code;
    stored  = code;
    start   = 1'b1;
    tick();
    lock_elapsed++;
    n_cmp++;
    if (locked !== 1'b0 || fail_cnt !== '0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL lock_expire: locked=%b fail_cnt=%0d busy=%b want 0 0 0",
                        locked, fail_cnt, busy);
    end
    tick();
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL lock_next_start: busy=%b want 1", busy);
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    n_cmp++;
    if (cyc != DIGITS || match !== 1'b1 || fail_cnt !== '0) begin
      n_bad++; $display("FAIL lock_post_cmp: cyc=%0d match=%b fail_cnt=%0d want %0d 1 0",
                        cyc, match, fail_cnt, DIGITS);
    end
    m_fail = 0;
    m_locked = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a;
    logic [W-1:0] b;
    int cyc;
    bit bad;
    a = W'($urandom);
    b = a ^ W'(24'h000F00);
    entered = a;
    stored  = a;
    start   = 1'b1;
    tick();
    bad = (busy !== 1'b1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
      if (cyc == 2) entered = b;
      if (done !== 1'b1 && (busy !== 1'b1)) bad = 1'b1;
    end
    m_fail = 0;
    n_cmp++;
    if (bad || cyc != DIGITS || match !== 1'b1) begin
      n_bad++; $display("FAIL b2b_first: bad=%b cyc=%0d match=%b want 0 %0d 1", bad, cyc, match, DIGITS);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("FAIL b2b_reaccept: busy=%b done=%b want 1 0", busy, done);
    end
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    m_fail++;
    n_cmp++;
    if (cyc != exp_lat(b, a) || match !== 1'b0 || fail_cnt !== FC_W'(m_fail)) begin
      n_bad++; $display("FAIL b2b_second: cyc=%0d match=%b fail_cnt=%0d want %0d 0 %0d",
                        cyc, match, fail_cnt, exp_lat(b, a), m_fail);
    end
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] s;
    logic [W-1:0] e;
    int mode;
    for (int i = 0; i < 12; i++) begin
      s = W'($urandom);
      mode = int'($urandom_range(0, 2));
      if (mode == 0) e = s;
      else if (mode == 1)
        e = s ^ (W'($urandom_range(1, 15)) << (DIGIT_W * int'($urandom_range(0, DIGITS - 1))));
      else e = W'($urandom);
      run_cmp(e, s, "random");
      if (m_locked) wait_lockout("random");
    end
  endtask

  task automatic test_reset_mid();
    entered = 24'h000000;
    stored  = 24'hFFFFFF;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, match, locked, fail_cnt} !== '0) begin
      n_bad++; $display("FAIL reset_async: busy=%b done=%b match=%b locked=%b fail_cnt=%0d want all 0",
                        busy, done, match, locked, fail_cnt);
    end
    tick();
    rst = 1'b0;
    m_fail = 0;
    m_locked = 1'b0;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_no_done: done=%b busy=%b want 0 0", done, busy);
    end
    run_cmp(24'h0A0B0C, 24'h0A0B0C, "post_reset");
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch_digit0();
    test_fail_sequence();
    test_lockout();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
